// File: rtl/alu_program_sequencer_if.sv
// Handshake bundle between the program sequencer, the ALU and the result consumer.
// master: the sequencer side; slave: the ALU / consumer side.
interface alu_program_sequencer_if;
  logic [11:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        res_valid;
  logic        res_halt;
  logic [11:0] res_data;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_ready;

  modport master (
    output instr, instr_valid, out_valid, out_data,
    input  instr_ready, res_valid, res_halt, res_data, out_ready
  );

  modport slave (
    input  instr, instr_valid, out_valid, out_data,
    output instr_ready, res_valid, res_halt, res_data, out_ready
  );
endinterface

// File: rtl/alu_program_sequencer.sv
// Host-side driver for the 12-bit ALU pipeline: program memory, instruction
// issue with valid/ready handshake, and a first-word-fall-through result FIFO.
module alu_program_sequencer #(
  parameter int PDEPTH = 16,
  parameter int PAW    = 4,
  parameter int RDEPTH = 8,
  parameter int RAW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           prog_we,
  input  logic [PAW-1:0] prog_addr,
  input  logic [11:0]    prog_data,
  input  logic           start,
  alu_program_sequencer_if.master bus,
  output logic           busy,
  output logic           done,
  output logic           err_runoff,
  output logic           err_ovf,
  output logic [PAW-1:0] pc,
  output logic [15:0]    issue_cnt
);

  localparam logic [3:0] OP_HALT = 4'hD;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;

  logic [11:0]    pmem [PDEPTH];
  logic           start_go;

  logic [11:0]    rbuf [RDEPTH];
  logic [RAW-1:0] wptr, rptr;
  logic [RAW:0]   count;
  logic           full, pop, push_ok;

  assign start_go = start && (state == IDLE || state == DONE);

  // Program memory: host writes only while the sequencer is not executing.
  always_ff @(posedge clk) begin
    if (prog_we && (state == IDLE || state == DONE))
      pmem[prog_addr] <= prog_data;
  end

  // Sequencer FSM; instr is reloaded from mem[pc] one cycle after each handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pc              <= '0;
      issue_cnt       <= '0;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      err_runoff      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            pc         <= '0;
            issue_cnt  <= '0;
            err_runoff <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
          end
        end
        RUN: begin
          if (!bus.instr_valid) begin
            bus.instr       <= pmem[pc];
            bus.instr_valid <= 1'b1;
          end else if (bus.instr_ready) begin
            bus.instr_valid <= 1'b0;
            pc              <= pc + 1'b1;
            if (issue_cnt != '1)
              issue_cnt <= issue_cnt + 16'd1;
            if (bus.instr[11:8] == OP_HALT) begin
              state <= DRAIN;
            end else if (pc == PAW'(PDEPTH - 1)) begin
              err_runoff <= 1'b1;
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (bus.res_valid && bus.res_halt) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign full    = (count == (RAW + 1)'(RDEPTH));
  assign pop     = bus.out_valid && bus.out_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign push_ok = bus.res_valid && (!full || pop);

  // Result storage; no reset needed since occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok)
      rbuf[wptr] <= bus.res_data;
  end

  // Result FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      err_ovf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (start_go)
        err_ovf <= 1'b0;
      if (bus.res_valid && full && !pop)
        err_ovf <= 1'b1;
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = bus.out_valid ? rbuf[rptr] : '0;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// Self-checking bench for alu_program_sequencer: scoreboard queues for issued
// instructions and FIFO results, plus a tiny ALU responder model.
module tb_alu_program_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic        start;
  logic        busy, done, err_runoff, err_ovf;
  logic [3:0]  pc;
  logic [15:0] issue_cnt;

  alu_program_sequencer_if bus ();

  alu_program_sequencer #(.PDEPTH(16), .PAW(4), .RDEPTH(8), .RAW(3)) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .start      (start),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err_runoff (err_runoff),
    .err_ovf    (err_ovf),
    .pc         (pc),
    .issue_cnt  (issue_cnt)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [11:0] pmem_m [16];
  logic [11:0] exp_instr [$];
  logic [11:0] exp_out [$];
  logic        model_ovf = 1'b0;
  logic        pend = 1'b0, pend_halt = 1'b0;
  logic        inj_valid = 1'b0;
  logic [11:0] inj_data = '0;
  logic        halt_seen = 1'b0;
  int unsigned n_issued = 0;
  int unsigned n_pops = 0;
  logic [11:0] last_pop = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive ALU/injected results, sample at negedge, return at posedge+1.
  task automatic cycle();
    logic        full_before, popping;
    logic [11:0] e;
    bus.res_valid = pend || inj_valid;
    bus.res_halt  = pend && pend_halt;
    bus.res_data  = pend ? 12'h001 : inj_data;
    pend      = 1'b0;
    inj_valid = 1'b0;
    @(negedge clk);
    if (reset) begin
      exp_out.delete();
      model_ovf = 1'b0;
      halt_seen = 1'b0;
    end else begin
      if (halt_seen) check("done_after_halt", 32'(done), 32'd1);
      halt_seen = bus.res_valid && bus.res_halt;
      if (bus.instr_valid && bus.instr_ready) begin
        n_issued++;
        if (exp_instr.size() == 0) check("instr_unexpected", 32'(bus.instr), 32'hFFFF_FFFF);
        else begin
          e = exp_instr.pop_front();
          check("instr", 32'(bus.instr), 32'(e));
        end
        if (bus.instr[11:8] == 4'hC || bus.instr[11:8] == 4'hD) begin
          pend      = 1'b1;
          pend_halt = (bus.instr[11:8] == 4'hD);
        end
      end
      check("out_valid", 32'(bus.out_valid), 32'(exp_out.size() != 0));
      full_before = (exp_out.size() == 8);
      popping     = bus.out_ready && (exp_out.size() != 0);
      if (popping) begin
        e = exp_out.pop_front();
        check("out_data", 32'(bus.out_data), 32'(e));
        n_pops++;
        last_pop = bus.out_data;
      end
      if (bus.res_valid) begin
        if (!full_before || popping) exp_out.push_back(bus.res_data);
        else model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    cycle();
    prog_we   = 1'b0;
    pmem_m[a] = d;
  endtask

  task automatic do_start();
    exp_instr.delete();
    for (int unsigned a = 0; a < 16; a++) begin
      exp_instr.push_back(pmem_m[a]);
      if (pmem_m[a][11:8] == 4'hD) break;
    end
    model_ovf = 1'b0;
    n_issued  = 0;
    start = 1'b1;
    cycle();
    start = 1'b0;
    check("start_busy", 32'(busy), 32'd1);
    check("start_valid_lat1", 32'(bus.instr_valid), 32'd0);
    cycle();
    check("start_valid_lat2", 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic run_until_done(input int unsigned budget, input string tag);
    for (int unsigned i = 0; i < budget && !done; i++) cycle();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic drain(input int unsigned expect_pops, input string tag);
    n_pops = 0;
    bus.out_ready = 1'b1;
    for (int unsigned i = 0; i < 20 && exp_out.size() != 0; i++) cycle();
    bus.out_ready = 1'b0;
    check({tag, "_pops"}, n_pops, expect_pops);
    check({tag, "_empty"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic load_basic();
    load(4'd0, 12'hA01);
    load(4'd1, 12'hC00);
    load(4'd2, 12'hD00);
  endtask

  initial begin
    reset = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0; start = 1'b0;
    bus.instr_ready = 1'b0; bus.out_ready = 1'b0;
    bus.res_valid = 1'b0; bus.res_halt = 1'b0; bus.res_data = '0;
    repeat (2) cycle();
    reset = 1'b0;
    check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", 32'(bus.instr), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_issue_cnt", 32'(issue_cnt), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_runoff", 32'(err_runoff), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);

    // Basic run
    load_basic();
    bus.instr_ready = 1'b1;
    do_start();
    run_until_done(40, "basic");
    check("basic_issue_cnt", 32'(issue_cnt), 32'd3);
    check("basic_pc", 32'(pc), 32'd3);
    check("basic_left", exp_instr.size(), 32'd0);
    check("basic_runoff", 32'(err_runoff), 32'd0);
    drain(2, "basic_drain");

    // Backpressure on the OUT instruction; a program write while busy must be ignored
    do_start();
    for (int unsigned i = 0; i < 20 && !(bus.instr_valid && bus.instr == 12'hC00); i++) cycle();
    check("bp_reach", 32'(bus.instr), 32'hC00);
    bus.instr_ready = 1'b0;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 12'hA55;
    for (int unsigned i = 0; i < 3; i++) begin
      cycle();
      prog_we = 1'b0;
      check("bp_instr", 32'(bus.instr), 32'hC00);
      check("bp_valid", 32'(bus.instr_valid), 32'd1);
      check("bp_pc", 32'(pc), 32'd1);
      check("bp_cnt", 32'(issue_cnt), 32'd1);
    end
    bus.instr_ready = 1'b1;
    run_until_done(40, "bp");
    check("bp_issue_cnt", 32'(issue_cnt), 32'd3);
    drain(2, "bp_drain");

    // Runoff: no HALT anywhere
    for (int unsigned a = 0; a < 16; a++) load(4'(a), 12'h000);
    do_start();
    run_until_done(80, "runoff");
    check("runoff_flag", 32'(err_runoff), 32'd1);
    check("runoff_pc", 32'(pc), 32'd0);
    check("runoff_cnt", 32'(issue_cnt), 32'd16);
    check("runoff_left", exp_instr.size(), 32'd0);
    repeat (3) cycle();
    check("runoff_nowrap", 32'(bus.instr_valid), 32'd0);

    // FIFO overflow: 9 pushes with no pops
    for (int unsigned i = 1; i <= 9; i++) begin
      inj_valid = 1'b1; inj_data = 12'(i);
      cycle();
    end
    check("ovf_flag", 32'(err_ovf), 32'(model_ovf));
    check("ovf_flag_set", 32'(err_ovf), 32'd1);
    check("ovf_valid", 32'(bus.out_valid), 32'd1);
    drain(8, "ovf_drain");
    check("ovf_last", 32'(last_pop), 32'd8);

    // Full FIFO with simultaneous push and pop
    reset = 1'b1; cycle(); reset = 1'b0;
    check("fp_ovf_clr", 32'(err_ovf), 32'd0);
    for (int unsigned i = 0; i < 8; i++) begin
      inj_valid = 1'b1; inj_data = 12'h010 + 12'(i);
      cycle();
    end
    bus.out_ready = 1'b1; inj_valid = 1'b1; inj_data = 12'hABC;
    cycle();
    bus.out_ready = 1'b0;
    check("fp_ovf", 32'(err_ovf), 32'd0);
    drain(8, "fp_drain");
    check("fp_last", 32'(last_pop), 32'hABC);

    // Reset while running, then rerun the same program
    load_basic();
    bus.instr_ready = 1'b1;
    do_start();
    for (int unsigned i = 0; i < 20 && n_issued < 2; i++) cycle();
    check("rr_issued", n_issued, 32'd2);
    reset = 1'b1; cycle(); reset = 1'b0;
    exp_instr.delete();
    check("rr_valid", 32'(bus.instr_valid), 32'd0);
    check("rr_pc", 32'(pc), 32'd0);
    check("rr_cnt", 32'(issue_cnt), 32'd0);
    check("rr_out_valid", 32'(bus.out_valid), 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    do_start();
    run_until_done(40, "rerun");
    check("rerun_cnt", 32'(issue_cnt), 32'd3);
    check("rerun_left", exp_instr.size(), 32'd0);
    drain(2, "rerun_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_program_sequencer.md
Name: alu_program_sequencer

Overview:
- Host-side driver for the 12-bit ALU pipeline: holds a small program memory, issues one instruction per accepted handshake, and collects the valid/halt/data result stream into an output FIFO.
- Instruction format: op[11:8], rd[7:6], rx[5:4], ry[3:2], imm[5:0]. OUT = 4'hC, HALT = 4'hD.
- Sits between the test/host interface and the ALU: writes instructions, reads results.

Parameters:
- PDEPTH, 16, program memory depth in words (power of 2).
- PAW, 4, program address width, log2(PDEPTH).
- RDEPTH, 8, result FIFO depth (power of 2).
- RAW, 3, result FIFO pointer width, log2(RDEPTH).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- prog_we  in  1  program memory write strobe.
- prog_addr  in  PAW  program write address.
- prog_data  in  12  program write data.
- start  in  1  one-cycle pulse that begins execution at address 0.
- instr  out  12  instruction to the ALU.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  ALU accepts instr this cycle.
- res_valid  in  1  ALU result strobe (OUT or HALT executed).
- res_halt  in  1  result came from HALT.
- res_data  in  12  ALU result data.
- out_valid  out  1  result FIFO non-empty.
- out_data  out  12  result FIFO head.
- out_ready  in  1  consumer pops head.
- busy  out  1  state is RUN or DRAIN.
- done  out  1  state is DONE.
- err_runoff  out  1  sticky: last address issued without a HALT.
- err_ovf  out  1  sticky: result dropped because the FIFO was full.
- pc  out  PAW  address of the next instruction to issue.
- issue_cnt  out  16  count of accepted instructions, saturating.

Behaviour:
- Reset values: state IDLE; pc=0, issue_cnt=0; instr_valid=0, instr=0; FIFO empty (out_valid=0, out_data=0); busy=0, done=0; err_runoff=0, err_ovf=0. Program memory is not cleared.
- Program memory writes:
  - Synchronous write on prog_we.
  - Accepted only in IDLE or DONE; ignored while busy.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE: start -> RUN with pc=0, issue_cnt=0, err flags cleared.
  - RUN:
    - instr_valid=1, instr=mem[pc] (registered, valid the cycle after pc changes).
    - Handshake fires when instr_valid & instr_ready: pc+1, issue_cnt+1.
    - instr and instr_valid must stay stable while instr_ready=0.
    - Fired instruction has op=4'hD -> DRAIN; instr_valid=0 from the next cycle.
    - Fired instruction is at pc=PDEPTH-1 and is not HALT -> err_runoff=1, go to DONE; no wrap.
  - DRAIN: instr_valid=0. On res_valid & res_halt -> DONE.
  - DONE: done=1. start -> RUN (same actions as from IDLE). The FIFO is not flushed on restart.
  - start in RUN or DRAIN is ignored.
- Result capture (any state):
  - Push: res_valid pushes res_data.
  - Pop: out_valid & out_ready pops the head.
  - out_data is the head entry, registered/first-word-fall-through, valid whenever out_valid=1.
  - Full and push without pop: data dropped, err_ovf=1 (sticky until start or reset).
  - Full with push and pop in the same cycle: both occur and occupancy is unchanged; no error.
  - Empty with push only: out_valid=1 on the next cycle.
  - Pointers wrap modulo RDEPTH. Occupancy counter is RAW+1 bits.
- Counter: issue_cnt saturates at 16'hFFFF.
- Mid-operation reset: returns to IDLE with the FIFO emptied and flags cleared. Any in-flight ALU result arriving after reset is captured normally.
- Latency:
  - start -> instr_valid=1: 2 cycles.
  - res_valid -> out_valid: 1 cycle.

Test Plan:
- Basic run: load mem[0]=12'hA01, mem[1]=12'hC00, mem[2]=12'hD00, pulse start, instr_ready=1, ALU returns res_valid with data 12'h001 for each OUT/HALT -> instr sequence A01,C00,D00; issue_cnt=3; FIFO holds 001,001; done=1 one cycle after the halt result; busy=0.
- Backpressure: as the basic run but instr_ready low for 3 cycles while instr=12'hC00 -> instr held at C00 with valid=1; pc unchanged until ready rises; issue_cnt ends at 3.
- Runoff: all 16 words = 12'h000 (OR), start -> 16 issues, err_runoff=1, done=1, pc=0, no wrap issue.
- FIFO overflow: out_ready=0, drive 9 res_valid pulses with data 1..9 -> out_valid=1, err_ovf=1, pops return 1..8.
- Full push+pop: FIFO full (8 entries), out_ready=1 with res_valid data 12'hABC in the same cycle -> occupancy stays 8, err_ovf=0, 12'hABC is the last entry popped.
- Reset in RUN: assert reset after 2 issues -> next cycle instr_valid=0, pc=0, issue_cnt=0, out_valid=0, busy=0; program memory intact; a new start reruns the same program.
